// File: rtl/cavlc_bit_window_if.sv
// Stream and consumer bundle for the CAVLC bit window.
// The producer/consumer side uses the master modport and the window uses the slave modport.
// Optional: BIT_POS_EN adds the BitPos signal.
interface cavlc_bit_window_if;
   logic [31:0] InData;
   logic        InValid;
   logic        InReady;
   logic [15:0] Window;
   logic        WindowValid;
   logic [6:0]  Fill;
   logic        Consume;
   logic [4:0]  ConsumeBits;
   logic        ConsumeErr;
`ifdef BIT_POS_EN
   logic [31:0] BitPos;
`endif

   modport master (
      output InData, InValid, Consume, ConsumeBits,
      input  InReady, Window, WindowValid, Fill, ConsumeErr
`ifdef BIT_POS_EN
      , input BitPos
`endif
   );

   modport slave (
      input  InData, InValid, Consume, ConsumeBits,
      output InReady, Window, WindowValid, Fill, ConsumeErr
`ifdef BIT_POS_EN
      , output BitPos
`endif
   );
endinterface

// File: rtl/cavlc_bit_window.sv
// CAVLC bitstream front end.
// Buffers up to 64 bits from 32-bit big-endian words and presents the oldest 16 bits as a
// left-aligned window. Each cycle 0..16 bits can be dropped.
// Optional: define BIT_POS_EN for the 32-bit consumed-bit counter on BitPos.
module cavlc_bit_window (
   input logic               Clk,
   input logic               nReset,
   input logic               Flush,
   cavlc_bit_window_if.slave bus
);

   localparam int unsigned WordW = 32;
   localparam int unsigned BufW  = 64;
   localparam int unsigned WinW  = 16;

   logic [BufW-1:0] buf_q, buf_d;
   logic [6:0]      fill_q, fill_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic            in_ready;
   logic            consume_fits;
   logic            consume_legal;
   logic            consume_illegal;
   logic            load;
   logic [4:0]      n_drop;
   logic [6:0]      fill_left;
   logic [BufW-1:0] buf_shifted;
   logic [BufW-1:0] word_aligned;

   // Accept a word only if it fits behind whatever survives this cycle's consume.
   always_comb begin
      in_ready = !Flush && (fill_q <= 7'd32);
      load     = bus.InValid && in_ready;
   end

   // Classify the consume request and compute the number of bits actually dropped.
   always_comb begin
      consume_fits    = (bus.ConsumeBits <= 5'd16) && ({2'b00, bus.ConsumeBits} <= fill_q);
      consume_legal   = bus.Consume && consume_fits;
      consume_illegal = bus.Consume && !consume_fits;
      n_drop          = consume_legal ? bus.ConsumeBits : 5'd0;
   end

   // Next buffer: drop consumed bits, then append the new word right after the survivors.
   always_comb begin
      buf_shifted  = buf_q << n_drop;
      fill_left    = fill_q - {2'b00, n_drop};
      // fill_left <= 32 whenever load is set, so the word never falls off the bottom.
      word_aligned = {bus.InData, {WordW{1'b0}}} >> fill_left;
      buf_d        = buf_shifted;
      fill_d       = fill_left;
      if (load) begin
         buf_d  = buf_shifted | word_aligned;
         fill_d = fill_left + 7'd32;
      end
      err_d = consume_illegal;
      if (Flush) begin
         buf_d  = '0;
         fill_d = '0;
         err_d  = 1'b0;
      end
      valid_d = (fill_d >= 7'd16);
   end

   // Buffer, fill level and status flags.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         buf_q   <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.InReady     = in_ready;
   assign bus.Window      = buf_q[BufW-1 -: WinW];
   assign bus.WindowValid = valid_q;
   assign bus.Fill        = fill_q;
   assign bus.ConsumeErr  = err_q;

`ifdef BIT_POS_EN
   logic [31:0] bit_pos_q, bit_pos_d;

   // Running count of legally consumed bits; wraps modulo 2^32.
   always_comb begin
      bit_pos_d = bit_pos_q + {27'd0, n_drop};
      if (Flush) begin
         bit_pos_d = '0;
      end
   end

   // Bit position register.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         bit_pos_q <= '0;
      end else begin
         bit_pos_q <= bit_pos_d;
      end
   end

   assign bus.BitPos = bit_pos_q;
`endif

   // Structural invariants: fill bounded and unused buffer bits kept at zero.
   a_fill_max : assert property (@(posedge Clk) disable iff (!nReset) fill_q <= 7'd64);
   a_buf_tail : assert property (@(posedge Clk) disable iff (!nReset)
      (buf_q & ({BufW{1'b1}} >> fill_q)) == '0);

endmodule

// File: tb/tb_cavlc_bit_window.sv
// Self-checking bench for cavlc_bit_window: directed scenarios plus random traffic
// compared against a bit-queue reference model.
module tb_cavlc_bit_window;

   logic Clk;
   logic nReset;
   logic Flush;

   cavlc_bit_window_if bus ();

   cavlc_bit_window dut (
      .Clk    (Clk),
      .nReset (nReset),
      .Flush  (Flush),
      .bus    (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model: buffered bits in stream order, oldest at index 0.
   bit          mq[$];
   logic [31:0] m_bitpos = '0;
   bit          m_err    = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_window();
      logic [15:0] w = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < mq.size()) w[15-i] = mq[i];
      end
      return w;
   endfunction

   task automatic check_outputs(input string tag);
      check_eq({tag, "_window"}, {48'd0, bus.Window}, {48'd0, model_window()});
      check_eq({tag, "_wvalid"}, {63'd0, bus.WindowValid}, {63'd0, mq.size() >= 16});
      check_eq({tag, "_fill"}, {57'd0, bus.Fill}, 64'(mq.size()));
      check_eq({tag, "_err"}, {63'd0, bus.ConsumeErr}, {63'd0, m_err});
`ifdef BIT_POS_EN
      check_eq({tag, "_bitpos"}, {32'd0, bus.BitPos}, {32'd0, m_bitpos});
`endif
   endtask

   // One clock cycle: drive inputs, check InReady, update model, check registered outputs.
   task automatic cycle(input string tag, input bit fl, input bit vld, input logic [31:0] dat,
                        input bit con, input logic [4:0] nb);
      bit ready_exp;
      Flush           = fl;
      bus.InValid     = vld;
      bus.InData      = dat;
      bus.Consume     = con;
      bus.ConsumeBits = nb;
      #1;
      ready_exp = !fl && (mq.size() <= 32);
      check_eq({tag, "_inready"}, {63'd0, bus.InReady}, {63'd0, ready_exp});
      if (fl) begin
         mq.delete();
         m_bitpos = '0;
         m_err    = 1'b0;
      end else begin
         if (con && nb <= 16 && int'(nb) <= mq.size()) begin
            for (int i = 0; i < int'(nb); i++) void'(mq.pop_front());
            m_bitpos = m_bitpos + 32'(nb);
            m_err    = 1'b0;
         end else begin
            m_err = con;
         end
         if (vld && ready_exp) begin
            for (int i = 31; i >= 0; i--) mq.push_back(dat[i]);
         end
      end
      @(posedge Clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      Flush           = 1'b0;
      bus.InValid     = 1'b0;
      bus.InData      = '0;
      bus.Consume     = 1'b0;
      bus.ConsumeBits = '0;
   endtask

   task automatic random_traffic(input int cycles);
      bit          fl, vld, con;
      logic [4:0]  nb;
      for (int c = 0; c < cycles; c++) begin
         fl  = ($urandom_range(0, 99) == 0);
         vld = ($urandom_range(0, 3) != 0);
         con = ($urandom_range(0, 3) != 0);
         nb  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(0, 16));
         cycle("rnd", fl, vld, $urandom, con, nb);
      end
   endtask

   initial begin
      idle_inputs();
      nReset = 1'b0;
      #12;
      check_outputs("reset");
      check_eq("reset_inready", {63'd0, bus.InReady}, 64'd1);
      @(negedge Clk);
      nReset = 1'b1;
      @(posedge Clk);
      #1;

      // Load then consume.
      cycle("ld", 0, 1, 32'hA5A50F0F, 0, 0);
      check_eq("ld_win", {48'd0, bus.Window}, 64'hA5A5);
      cycle("c3", 0, 0, 0, 1, 3);
      check_eq("c3_win", {48'd0, bus.Window}, 64'h2D28);
      check_eq("c3_fill", {57'd0, bus.Fill}, 64'd29);
      cycle("fl0", 1, 0, 0, 0, 0);

      // Full buffer and back-pressure.
      cycle("full1", 0, 1, 32'h12345678, 0, 0);
      cycle("full2", 0, 1, 32'h9ABCDEF0, 0, 0);
      check_eq("full_fill", {57'd0, bus.Fill}, 64'd64);
      cycle("hold", 0, 1, 32'h11111111, 0, 0);
      cycle("hold_c16a", 0, 1, 32'h11111111, 1, 16);
      check_eq("bp_fill48", {57'd0, bus.Fill}, 64'd48);
      cycle("hold_c16b", 0, 1, 32'h11111111, 1, 16);
      check_eq("bp_fill32", {57'd0, bus.Fill}, 64'd32);
      cycle("hold_acc", 0, 1, 32'h11111111, 0, 0);
      check_eq("bp_fill64", {57'd0, bus.Fill}, 64'd64);
      cycle("fl1", 1, 0, 0, 0, 0);

      // Simultaneous consume and load.
      cycle("sim_ld", 0, 1, 32'hFFFFF000, 0, 0);
      cycle("sim_c12", 0, 0, 0, 1, 12);
      check_eq("sim_win1", {48'd0, bus.Window}, 64'hFF00);
      cycle("sim_both", 0, 1, 32'h80000000, 1, 5);
      check_eq("sim_win2", {48'd0, bus.Window}, 64'hE001);
      check_eq("sim_fill", {57'd0, bus.Fill}, 64'd47);
      cycle("fl2", 1, 0, 0, 0, 0);

      // Illegal consumes.
      cycle("il_ld", 0, 1, 32'hC3C3C3C3, 0, 0);
      cycle("il_c16", 0, 0, 0, 1, 16);
      cycle("il_c8", 0, 0, 0, 1, 8);
      cycle("il_c10", 0, 0, 0, 1, 10);
      check_eq("il_err_pulse", {63'd0, bus.ConsumeErr}, 64'd1);
      cycle("il_idle", 0, 0, 0, 0, 0);
      check_eq("il_err_clear", {63'd0, bus.ConsumeErr}, 64'd0);
      cycle("il_ld2", 0, 1, 32'h0F0F0F0F, 0, 0);
      cycle("il_c17", 0, 0, 0, 1, 17);
      cycle("il_c0", 0, 0, 0, 1, 0);

      // Flush priority over load and consume (Fill = 40 here).
      cycle("fp", 1, 1, 32'hDEADBEEF, 1, 4);
      check_eq("fp_fill", {57'd0, bus.Fill}, 64'd0);

      // Bit position: 3 + 16 + 7, then an ignored 20.
      cycle("bp_ld", 0, 1, 32'h76543210, 0, 0);
      cycle("bp_c3", 0, 0, 0, 1, 3);
      cycle("bp_c16", 0, 0, 0, 1, 16);
      cycle("bp_c7", 0, 0, 0, 1, 7);
      cycle("bp_c20", 0, 0, 0, 1, 20);
`ifdef BIT_POS_EN
      check_eq("bp_total", {32'd0, bus.BitPos}, 64'd26);
`endif

      random_traffic(3000);

      // Asynchronous reset mid-operation.
      nReset = 1'b0;
      #2;
      mq.delete();
      m_bitpos = '0;
      m_err    = 1'b0;
      check_outputs("arst");
      idle_inputs();
      @(negedge Clk);
      nReset = 1'b1;
      @(posedge Clk);
      #1;

      random_traffic(1000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
